gpi_irq: RTL and testbench

//  CSR-mapped general-purpose input block with per-pin edge interrupts.
//  It is the input-side counterpart to the GPO block and uses the same
//  8-bit CSR bus (5-bit address, registered read data, single-cycle

---
 rtl/gpi_irq.sv | 137 +++++++++++++
 tb/tb_gpi_irq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpi_irq.sv
`default_nettype none
// ============================================================================
// Module   : gpi_irq
// Purpose  : CSR-mapped general-purpose input block. It synchronises
//            asynchronous pins, exposes their level, latches selected edges
//            into sticky pending bits, and drives one level interrupt.
// Ports    : clk     - clock
//            rst     - synchronous active-high reset
//            csr_a   - CSR address (5 bits)
//            csr_di  - CSR write data (8 bits)
//            csr_we  - CSR write strobe, one cycle per write
//            csr_do  - CSR read data, registered
//            in      - asynchronous input pins (NUM_GPIOS bits)
//            irq     - interrupt request, active-high level, registered
// Register map (offset from BASE_ADDR):
//            +0 DATA RO, +1 IP W1C, +2 IE RW, +3 EDGE RW (0 rise / 1 fall)
// Revision : 1.0 - initial release
// ============================================================================
module gpi_irq #(
    parameter logic [4:0] BASE_ADDR = 5'b0,
    parameter int         NUM_GPIOS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           csr_a,
    input  logic [7:0]           csr_di,
    input  logic                 csr_we,
    output logic [7:0]           csr_do,
    input  logic [NUM_GPIOS-1:0] in,
    output logic                 irq
);

    // Bits at and above NUM_GPIOS are never stored, so they read as zero.
    localparam logic [7:0] c_pin_mask = 8'hFF >> (8 - NUM_GPIOS);
    localparam logic [1:0] c_off_data = 2'd0;
    localparam logic [1:0] c_off_ip   = 2'd1;
    localparam logic [1:0] c_off_ie   = 2'd2;
    localparam logic [1:0] c_off_edge = 2'd3;
    localparam logic [1:0] c_armed    = 2'd3;

    logic [NUM_GPIOS-1:0] r_sync1;
    logic [NUM_GPIOS-1:0] r_sync2;
    logic [NUM_GPIOS-1:0] r_prev;
    logic [1:0]           r_arm;
    logic [7:0]           r_ip;
    logic [7:0]           r_ie;
    logic [7:0]           r_edge;
    logic [7:0]           r_csr_do;
    logic                 r_irq;

    logic [4:0] w_off;
    logic       w_hit;
    logic [7:0] w_level;
    logic [7:0] w_last;
    logic [7:0] w_rise;
    logic [7:0] w_fall;
    logic [7:0] w_ev;
    logic [7:0] w_clr;
    logic       w_ie_we;
    logic       w_edge_we;
    logic [7:0] w_rd;

    // BASE_ADDR <= 28 guarantees that an address below the window wraps to
    // an offset of at least 4, so the upper offset bits alone decode the hit.
    assign w_off = csr_a - BASE_ADDR;
    assign w_hit = (w_off[4:2] == 3'b000);

    always_comb begin
        w_level                = 8'h00;
        w_last                 = 8'h00;
        w_level[NUM_GPIOS-1:0] = r_sync2;
        w_last[NUM_GPIOS-1:0]  = r_prev;
    end

    assign w_rise = w_level & ~w_last;
    assign w_fall = w_last & ~w_level;

    // Events are suppressed until the sync pipeline has been refilled after
    // reset, so pins that are already high do not look like rising edges.
    assign w_ev = (r_arm == c_armed) ? ((w_rise & ~r_edge) | (w_fall & r_edge))
                                     : 8'h00;

    assign w_clr     = (csr_we && w_hit && (w_off[1:0] == c_off_ip))
                     ? (csr_di & c_pin_mask) : 8'h00;
    assign w_ie_we   = csr_we && w_hit && (w_off[1:0] == c_off_ie);
    assign w_edge_we = csr_we && w_hit && (w_off[1:0] == c_off_edge);

    always_comb begin
        w_rd = 8'h00;
        if (w_hit) begin
            case (w_off[1:0])
                c_off_data: w_rd = w_level;
                c_off_ip:   w_rd = r_ip;
                c_off_ie:   w_rd = r_ie;
                c_off_edge: w_rd = r_edge;
                default:    w_rd = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_prev   <= '0;
            r_arm    <= 2'd0;
            r_ip     <= 8'h00;
            r_ie     <= 8'h00;
            r_edge   <= 8'h00;
            r_csr_do <= 8'h00;
            r_irq    <= 1'b0;
        end else begin
            r_sync1 <= in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (r_arm != c_armed) begin
                r_arm <= r_arm + 2'd1;
            end
            // OR-ing the event after the clear makes a new event win over a
            // simultaneous W1C of the same bit.
            r_ip <= (r_ip & ~w_clr) | w_ev;
            if (w_ie_we) begin
                r_ie <= csr_di & c_pin_mask;
            end
            if (w_edge_we) begin
                r_edge <= csr_di & c_pin_mask;
            end
            r_irq    <= |(r_ip & r_ie);
            r_csr_do <= w_rd;
        end
    end

    assign csr_do = r_csr_do;
    assign irq    = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_gpi_irq.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpi_irq
// Purpose  : Self-checking bench for gpi_irq. Two instances share one CSR
//            bus: an 8-pin block at base 0 and a 4-pin block at base 8.
//            A reference model keeps a history of sampled pin values and
//            derives levels, edges, pending bits and reads from it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpi_irq;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] a;
    logic [7:0] di;
    logic       we;
    logic [7:0] pins;
    logic [7:0] do8;
    logic [7:0] do4;
    logic       irq8;
    logic       irq4;

    int checks = 0;
    int errors = 0;
    int bit_i;

    always #5 clk = ~clk;

    gpi_irq #(.BASE_ADDR(5'd0), .NUM_GPIOS(8)) u_dut8 (
        .clk(clk), .rst(rst), .csr_a(a), .csr_di(di), .csr_we(we),
        .csr_do(do8), .in(pins), .irq(irq8)
    );

    gpi_irq #(.BASE_ADDR(5'd8), .NUM_GPIOS(4)) u_dut4 (
        .clk(clk), .rst(rst), .csr_a(a), .csr_di(di), .csr_we(we),
        .csr_do(do4), .in(pins[3:0]), .irq(irq4)
    );

    // ---------------- reference model ----------------
    logic [7:0] m_ip[2];
    logic [7:0] m_ie[2];
    logic [7:0] m_edge[2];
    logic [7:0] m_do[2];
    logic       m_irq[2];
    logic [7:0] hist[$];   // hist[k] = pins sampled k+1 edges ago
    int         m_age;     // non-reset edges since reset, capped at 3

    function automatic logic [4:0] base_of(input int d);
        return (d == 0) ? 5'd0 : 5'd8;
    endfunction

    function automatic int n_of(input int d);
        return (d == 0) ? 8 : 4;
    endfunction

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic model_edge();
        logic [7:0] lvl, old, mask, ev, rdv;
        logic [4:0] off;
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_ip[d] = 8'h00; m_ie[d] = 8'h00; m_edge[d] = 8'h00;
                m_do[d] = 8'h00; m_irq[d] = 1'b0;
            end
            hist  = '{8'h00, 8'h00, 8'h00};
            m_age = 0;
            return;
        end
        lvl = hist[1];   // level visible to software
        old = hist[2];   // one sample older
        for (int d = 0; d < 2; d++) begin
            mask = 8'hFF >> (8 - n_of(d));
            ev   = 8'h00;
            if (m_age >= 3) begin
                for (int i = 0; i < 8; i++) begin
                    // a pin that changed to the polarity selected by EDGE
                    if ((lvl[i] != old[i]) && (lvl[i] == !m_edge[d][i])) ev[i] = 1'b1;
                end
            end
            ev       = ev & mask;
            m_irq[d] = ((m_ip[d] & m_ie[d]) != 8'h00);
            off      = a - base_of(d);
            case (off)
                5'd0:    rdv = lvl & mask;
                5'd1:    rdv = m_ip[d];
                5'd2:    rdv = m_ie[d];
                5'd3:    rdv = m_edge[d];
                default: rdv = 8'h00;
            endcase
            m_do[d] = rdv;
            if (we && off == 5'd1) m_ip[d] = m_ip[d] & ~di;
            m_ip[d] = (m_ip[d] | ev) & mask;
            if (we && off == 5'd2) m_ie[d] = di & mask;
            if (we && off == 5'd3) m_edge[d] = di & mask;
        end
        hist.push_front(pins);
        void'(hist.pop_back());
        if (m_age < 3) m_age++;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("do8",  do8, m_do[0]);
        chk("irq8", {7'b0, irq8}, {7'b0, m_irq[0]});
        chk("do4",  do4, m_do[1]);
        chk("irq4", {7'b0, irq4}, {7'b0, m_irq[1]});
    endtask

    task automatic wr(input logic [4:0] ad, input logic [7:0] d);
        a = ad; di = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic rd8(input logic [4:0] ad, input logic [7:0] exp, input string tag);
        a = ad; we = 1'b0;
        tick();
        chk(tag, do8, exp);
    endtask

    task automatic rd4(input logic [4:0] ad, input logic [7:0] exp, input string tag);
        a = ad; we = 1'b0;
        tick();
        chk(tag, do4, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int d = 0; d < 2; d++) begin
            m_ip[d] = 8'h00; m_ie[d] = 8'h00; m_edge[d] = 8'h00;
            m_do[d] = 8'h00; m_irq[d] = 1'b0;
        end
        hist  = '{8'h00, 8'h00, 8'h00};
        m_age = 0;

        // Pins high through reset: arming must hide the apparent rising edge.
        rst = 1'b1; a = 5'd0; di = 8'h00; we = 1'b0; pins = 8'hFF;
        tick(); tick();
        chk("rst_do8", do8, 8'h00);
        chk("rst_irq8", {7'b0, irq8}, 8'h00);
        rst = 1'b0;
        repeat (10) tick();
        chk("t1_irq", {7'b0, irq8}, 8'h00);
        rd8(5'd0, 8'hFF, "t1_data");
        rd8(5'd1, 8'h00, "t1_ip");
        rd4(5'd8, 8'h0F, "t1_data4");
        rd4(5'd9, 8'h00, "t1_ip4");

        // Rising edge on pin 0 with timing of IP and irq.
        wr(5'd2, 8'h01);
        wr(5'd3, 8'h00);
        pins[0] = 1'b0;
        repeat (4) tick();
        rd8(5'd1, 8'h00, "t2_fall_ignored");
        pins[0] = 1'b1;
        repeat (3) tick();
        chk("t2_ip_lag", do8, 8'h00);
        chk("t2_irq_lag", {7'b0, irq8}, 8'h00);
        tick();
        chk("t2_ip_set", do8, 8'h01);
        chk("t2_irq_set", {7'b0, irq8}, 8'h01);
        wr(5'd1, 8'h01);
        chk("t2_irq_hold", {7'b0, irq8}, 8'h01);
        tick();
        chk("t2_ip_clr", do8, 8'h00);
        chk("t2_irq_clr", {7'b0, irq8}, 8'h00);

        // Falling-edge selection on pin 1.
        wr(5'd3, 8'h02);
        wr(5'd2, 8'h02);
        pins[1] = 1'b0;
        repeat (4) tick();
        rd8(5'd1, 8'h02, "t3_fall_set");
        chk("t3_irq", {7'b0, irq8}, 8'h01);
        wr(5'd1, 8'h02);
        tick(); tick();
        chk("t3_irq_clr", {7'b0, irq8}, 8'h00);
        pins[1] = 1'b1;
        repeat (5) tick();
        rd8(5'd1, 8'h00, "t3_rise_ignored");

        // W1C of IP[2] colliding with a new rising event on pin 2.
        pins[2] = 1'b0; repeat (4) tick();
        pins[2] = 1'b1; repeat (4) tick();
        rd8(5'd1, 8'h04, "t4_ip_set");
        wr(5'd1, 8'h04);
        rd8(5'd1, 8'h00, "t4_pre_clr");
        pins[2] = 1'b0; repeat (4) tick();
        pins[2] = 1'b1;
        tick(); tick();
        wr(5'd1, 8'h04);
        rd8(5'd1, 8'h04, "t4_set_wins");
        wr(5'd1, 8'h04);
        rd8(5'd1, 8'h00, "t4_cleared");

        // Narrow instance at a non-zero base: masking and window edges.
        wr(5'd10, 8'hFF);
        rd4(5'd10, 8'h0F, "t5_ie4");
        rd4(5'd12, 8'h00, "t5_above_win4");
        rd4(5'd7, 8'h00, "t5_below_win4");
        wr(5'd11, 8'hFF);
        rd4(5'd11, 8'h0F, "t5_edge4");
        rd8(5'd10, 8'h00, "t5_outside8");
        wr(5'd11, 8'h00);
        wr(5'd10, 8'h00);
        wr(5'd9, 8'hFF);
        wr(5'd0, 8'h55);
        rd8(5'd0, 8'hFF, "t5_data_ro");

        // Reset while pending and interrupting.
        wr(5'd3, 8'h00);
        pins = 8'hF0; repeat (4) tick();
        wr(5'd1, 8'hFF);
        pins = 8'hFF; repeat (4) tick();
        wr(5'd2, 8'h0F);
        tick();
        rd8(5'd1, 8'h0F, "t6_ip");
        chk("t6_irq", {7'b0, irq8}, 8'h01);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_irq_rst", {7'b0, irq8}, 8'h00);
        chk("t6_do_rst", do8, 8'h00);
        rd8(5'd1, 8'h00, "t6_ip_rst");
        rd8(5'd2, 8'h00, "t6_ie_rst");
        repeat (5) tick();
        rd8(5'd1, 8'h00, "t6_rearm");

        // Randomised traffic checked cycle by cycle against the model.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                bit_i = $urandom_range(0, 7);
                pins[bit_i] = ~pins[bit_i];
            end
            a   = 5'($urandom_range(0, 13));
            we  = ($urandom_range(0, 2) == 0);
            di  = 8'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        we  = 1'b0;
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
